hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage CPU. It keeps its own shadow copy of the register-write information for the ID/EX, EX/MEM and MEM/WB stages, and produces the EX-stage operand forwarding selects. It also detects load-use hazards and inserts one-cycle stalls, and squashes younger instructions on a taken branch. Sits beside the main pipeline registers and drives the PC/IF-ID enables, the ID/EX bubble/flush controls and the EX operand muxes.

Parameters:
ZERO_REG, 5'd31, register index that is never written (XZR); it never matches for forwarding or stall.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
hold  input  1  external freeze (memory wait); the whole pipeline holds.
id_valid  input  1  the ID stage holds a real instruction.
id_src1  input  5  ID first source register (Rn).
id_src1_used  input  1  id_src1 is read by the ID instruction.
id_src2  input  5  ID second source register (Rm, or Rd for STUR/CBZ).
id_src2_used  input  1  id_src2 is read by the ID instruction.
id_dst  input  5  ID destination register.
id_wren  input  1  the ID instruction writes the register file.
id_memrd  input  1  the ID instruction is a load.
ex_br_taken  input  1  the branch in EX resolved taken this cycle.
fw_a  output  2  EX operand A select: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
fw_b  output  2  EX operand B select, same encoding as fw_a.
stall  output  1  hold PC and IF/ID; load a bubble into ID/EX.
flush_ifid  output  1  squash the IF/ID register.
flush_idex  output  1  load a bubble into ID/EX.
stall_cnt  output  CNT_W  count of stall cycles.
flush_cnt  output  CNT_W  count of taken-branch flushes.

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush):
  - All slot wren/memrd bits = 0; all slot dst = ZERO_REG.
  - Counters = 0.
  - fw_a, fw_b = 00; stall and flush outputs = 0 while reset is high and until new inputs arrive.
- Shadow slots:
  - IDEX holds {src1, src1_used, src2, src2_used, dst, wren, memrd}.
  - EXMEM and MEMWB hold {dst, wren}.
- Each rising edge with hold=0:
  - MEMWB <= EXMEM.
  - EXMEM <= IDEX.
  - IDEX <= the ID fields, or a bubble (wren=0, memrd=0, used bits 0, dst=ZERO_REG) if id_valid=0, stall=1 or flush_idex=1.
- hold=1: all slots and counters keep their values; stall, flush_ifid and flush_idex are forced 0; fw_a and fw_b stay valid.
- Forwarding is combinational from the slots, for the instruction in EX (slot IDEX). For each source s with used=1:
  - 01 if EXMEM.wren and EXMEM.dst==s and dst!=ZERO_REG.
  - Else 10 if MEMWB.wren and MEMWB.dst==s and dst!=ZERO_REG.
  - Else 00.
  - The most recent producer wins; 11 is never driven. Unused sources give 00.
- Load-use hazard (raw, combinational):
  - Condition: id_valid, IDEX.memrd, IDEX.wren, IDEX.dst!=ZERO_REG, and IDEX.dst equals id_src1 (with src1_used) or id_src2 (with src2_used).
  - Effect: stall=1 for exactly one cycle. After the bubble, the consumer reaches EX with the load in MEMWB and gets fw=10.
- Taken branch (ex_br_taken=1, hold=0):
  - flush_ifid=1 and flush_idex=1 in the same cycle.
  - Flush has priority: stall=0 that cycle even if a load-use hazard is present.
  - The branch itself advances to EXMEM normally.
- Counters, when hold=0:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with ex_br_taken=1.
  - Both saturate at all-ones and never wrap.
- Latency: forwarding and stall/flush are zero-cycle (combinational from slot state plus ID inputs). Slot state updates one edge later.

Test Plan:
1. Reset mid-stall: assert a load-use hazard, then pulse reset -> stall=0, fw_a=fw_b=00, stall_cnt=0; after release, ADD X1 issues cleanly with no stall.
2. EX/MEM forward: ADD X3 followed by SUB X4,X3,X7 -> fw_a=01, fw_b=00 in the SUB's EX cycle; one cycle later an unrelated instruction sees 00.
3. Double producer: ADD X5; ADD X5; ORR X6,X5,X5 -> fw_a=fw_b=01 (never 10 or 11). With a NOP between the second producer and the ORR -> 10.
4. Load-use: LDUR X2 followed by ADD X8,X9,X2 -> stall=1 for exactly one cycle, stall_cnt=1, ID/EX bubble; the ADD then reaches EX with fw_b=10.
5. XZR: LDUR X31 followed by ADD reading X31 -> stall=0 and fw=00. ADD X31 followed by a reader of X31 -> fw=00.
6. Branch priority and hold:
   - ex_br_taken coincident with a load-use hazard -> flush_ifid=flush_idex=1, stall=0, flush_cnt+1, stall_cnt unchanged.
   - The same stimulus under hold=1 -> all three outputs 0 and counters unchanged until hold drops.
   - Preload stall_cnt to 0xFFFF (via 65535 stalls or a force), then one more stall -> stays 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow ID/EX, EX/MEM, MEM/WB write info, EX operand
// forwarding selects, load-use stall, taken-branch flush and saturating event counters.
module hazard_ctrl #(
  parameter logic [4:0] ZERO_REG = 5'd31,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic             id_src1_used,
  input  logic [4:0]       id_src2,
  input  logic             id_src2_used,
  input  logic [4:0]       id_dst,
  input  logic             id_wren,
  input  logic             id_memrd,
  input  logic             ex_br_taken,
  output logic [1:0]       fw_a,
  output logic [1:0]       fw_b,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0] ie_src1, ie_src2, ie_dst;
  logic       ie_src1_used, ie_src2_used, ie_wren, ie_memrd;
  logic [4:0] em_dst, mw_dst;
  logic       em_wren, mw_wren;

  logic       load_use, flush, bubble;

  function automatic logic [1:0] fw_sel(input logic [4:0] src, input logic used,
                                        input logic [4:0] e_dst, input logic e_wren,
                                        input logic [4:0] m_dst, input logic m_wren);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != ZERO_REG) begin
      if (e_wren && e_dst == src)      sel = 2'b01;
      else if (m_wren && m_dst == src) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    fw_a = fw_sel(ie_src1, ie_src1_used, em_dst, em_wren, mw_dst, mw_wren);
    fw_b = fw_sel(ie_src2, ie_src2_used, em_dst, em_wren, mw_dst, mw_wren);
  end

  always_comb begin
    load_use = id_valid && ie_memrd && ie_wren && (ie_dst != ZERO_REG) &&
               ((id_src1_used && id_src1 == ie_dst) || (id_src2_used && id_src2 == ie_dst));
    // Reset gating keeps a stray branch input from flushing while the slots are cleared.
    flush      = ex_br_taken && !hold && !reset;
    stall      = load_use && !hold && !ex_br_taken && !reset;
    flush_ifid = flush;
    flush_idex = flush;
    bubble     = !id_valid || stall || flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_src1      <= ZERO_REG;
      ie_src1_used <= 1'b0;
      ie_src2      <= ZERO_REG;
      ie_src2_used <= 1'b0;
      ie_dst       <= ZERO_REG;
      ie_wren      <= 1'b0;
      ie_memrd     <= 1'b0;
      em_dst       <= ZERO_REG;
      em_wren      <= 1'b0;
      mw_dst       <= ZERO_REG;
      mw_wren      <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else if (!hold) begin
      mw_dst  <= em_dst;
      mw_wren <= em_wren;
      em_dst  <= ie_dst;
      em_wren <= ie_wren;
      if (bubble) begin
        ie_src1      <= ZERO_REG;
        ie_src1_used <= 1'b0;
        ie_src2      <= ZERO_REG;
        ie_src2_used <= 1'b0;
        ie_dst       <= ZERO_REG;
        ie_wren      <= 1'b0;
        ie_memrd     <= 1'b0;
      end else begin
        ie_src1      <= id_src1;
        ie_src1_used <= id_src1_used;
        ie_src2      <= id_src2;
        ie_src2_used <= id_src2_used;
        ie_dst       <= id_dst;
        ie_wren      <= id_wren;
        ie_memrd     <= id_memrd;
      end
      if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
